// File: rtl/wdt_cmd_sequencer.sv
// Byte-stream command sequencer for the triple watchdog. It decodes KICK, ARM, SET_TIMEOUT
// and SET_PRESCALE commands, drives the per-channel controls and latches expiry and error status.
module wdt_cmd_sequencer #(
  parameter int unsigned TW = 8,
  parameter int unsigned PW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  input  logic [7:0]    cmd_data_i,
  output logic          cmd_ready_o,
  input  logic [2:0]    ch_expired_i,
  output logic [TW-1:0] ch_timeout_o,
  output logic [2:0]    ch_load_o,
  output logic [2:0]    ch_arm_o,
  output logic [2:0]    ch_kick_o,
  output logic [PW-1:0] prescale_o,
  output logic [2:0]    exp_sticky_o,
  output logic          err_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {StIdle, StArg, StExec} state_e;

  localparam logic [1:0] OpKick     = 2'b00;
  localparam logic [1:0] OpArm      = 2'b01;
  localparam logic [1:0] OpTimeout  = 2'b10;
  localparam logic [1:0] OpPrescale = 2'b11;

  state_e        state_q, state_d;
  logic [7:0]    hdr_q, hdr_d;
  logic [TW-1:0] data_q, data_d;
  logic [2:0]    arm_q, arm_d;
  logic [2:0]    sticky_q, sticky_d;
  logic          err_q, err_d;
  logic [PW-1:0] pre_q, pre_d;

  logic [1:0] op;
  logic [1:0] ch;
  logic [3:0] arg;
  logic [2:0] sel;
  logic [2:0] clr;

  assign op  = hdr_q[7:6];
  assign ch  = hdr_q[5:4];
  assign arg = hdr_q[3:0];
  assign sel = (ch == 2'd3) ? 3'b111 : (3'b001 << ch);

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    data_d       = data_q;
    arm_d        = arm_q;
    err_d        = err_q;
    pre_d        = pre_q;
    clr          = 3'b000;
    cmd_ready_o  = 1'b1;
    ch_kick_o    = 3'b000;
    ch_load_o    = 3'b000;
    ch_timeout_o = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          hdr_d   = cmd_data_i;
          state_d = (cmd_data_i[7:6] == OpTimeout) ? StArg : StExec;
        end
      end
      StArg: begin
        if (cmd_valid_i) begin
          data_d  = cmd_data_i[TW-1:0];
          state_d = StExec;
        end
      end
      StExec: begin
        cmd_ready_o = 1'b0;
        state_d     = StIdle;
        unique case (op)
          OpKick: ch_kick_o = sel & arm_q & ~sticky_q;
          OpArm: begin
            if (arg[0]) begin
              arm_d = arm_q | sel;
            end else begin
              arm_d = arm_q & ~sel;
              clr   = sel;
            end
            if (ch == 2'd3 && arg[3]) err_d = 1'b0;
          end
          OpTimeout: begin
            // A zero value or any armed target rejects the whole load.
            if (data_q == '0 || (sel & arm_q) != 3'b000) begin
              err_d = 1'b1;
            end else begin
              ch_load_o    = sel;
              ch_timeout_o = data_q;
            end
          end
          OpPrescale: begin
            if (ch == 2'd3) pre_d = arg[PW-1:0];
            else            err_d = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase

    // Disarm clear takes priority over a same-cycle expiry.
    sticky_d = (sticky_q | (ch_expired_i & arm_q)) & ~clr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      hdr_q    <= '0;
      data_q   <= '0;
      arm_q    <= '0;
      sticky_q <= '0;
      err_q    <= 1'b0;
      pre_q    <= '0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      data_q   <= data_d;
      arm_q    <= arm_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
      pre_q    <= pre_d;
    end
  end

  assign ch_arm_o     = arm_q;
  assign exp_sticky_o = sticky_q;
  assign err_o        = err_q;
  assign prescale_o   = pre_q;
  assign busy_o       = (state_q != StIdle);

endmodule
